spi_slave_if: RTL
=================

SPI_SLAVE_IF -- requirements
Module: spi_slave_if

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer flops on spi_sck, spi_ss and spi_mosi (legal 2..3).
REQ-002 SHALL have port clk, input, 1, system clock; the only clock.
REQ-003 SHALL have port rst, input, 1, system reset, asynchronous, active-high.
REQ-004 SHALL have port din, input, 8, bus data: TX byte on wr; config on cmd (bit0 CPHA, bit1 CPOL, bit2 endianness: 0 MSB first, 1 LSB first).
REQ-005 SHALL have port cmd, input, 1, config write strobe.
REQ-006 SHALL have port wr, input, 1, TX byte write strobe.
REQ-007 SHALL have port rd, input, 1, RX byte read strobe.
REQ-008 SHALL have port dout, output, 9, {0, byte} on a successful read, else {1, 8'h00}.
REQ-009 SHALL have port ack, output, 1, registered bus acknowledge.
REQ-010 SHALL have port ovr, output, 1, sticky RX overrun flag.
REQ-011 SHALL have ports spi_sck, spi_ss (active low) and spi_mosi as inputs, 1 bit each, from the external master.
REQ-012 SHALL have ports spi_miso, output, 1, and spi_miso_oe, output, 1, high while the synchronized SS is asserted.

Function
REQ-013 spi_sck, spi_ss and spi_mosi SHALL each pass through SYNC_STAGES flops; edge detection SHALL compare the last synchronized stage with one further flop.
REQ-014 Sample edge SHALL be the leading SCK edge when CPHA=0 and the trailing edge when CPHA=1; leading = rising if CPOL=0, falling if CPOL=1; the shift edge is the opposite edge.
REQ-015 SS falling (synchronized) SHALL clear the 3-bit bit counter and load the shift register with the TX FIFO head (popped), or 8'hFF if the TX FIFO is empty (underrun, no other effect).
REQ-016 With CPHA=0, spi_miso SHALL present the first bit from the cycle after the load; with CPHA=1, the first bit SHALL appear on the first shift edge.
REQ-017 Each sample edge SHALL shift spi_mosi in and increment the counter; on the 8th sample the byte, endianness-ordered, SHALL be pushed to the RX FIFO and the next TX byte loaded per REQ-015, within one clk.
REQ-018 RX byte complete with RX FIFO full SHALL drop the byte and set the overrun flag.
REQ-019 SS rising mid-byte SHALL discard the partial byte, clear the counter and leave both FIFOs unchanged.
REQ-020 The config register SHALL update on cmd only while synchronized SS is deasserted; cmd during SS asserted SHALL be acked and ignored.
REQ-021 A wr SHALL be accepted only if the TX FIFO is not full; a rejected wr SHALL not be acked.
REQ-022 A rd with RX FIFO non-empty SHALL pop and drive dout={0,byte} combinationally in the same cycle; a rd when empty SHALL return {1,8'h00}.
REQ-023 ack SHALL be registered: ack <= accepted wr | rd | cmd, one cycle after the strobe.
REQ-024 A TX pop and a bus wr in the same cycle SHALL both take effect, as SHALL an RX push and a bus rd.
REQ-025 Correct operation SHALL require SCK period >= 8 clk periods; behaviour above that rate is undefined.

Reset
REQ-026 rst SHALL asynchronously set: config 3'b000, counter 0, shift register 8'hFF, both FIFOs empty, ovr 0, ack 0, synchronizers and edge flops to idle (SS 1, SCK 0, MOSI 0).
REQ-027 After reset, spi_miso SHALL be 1, spi_miso_oe 0 and dout {1,8'h00}.
REQ-028 rst mid-transfer SHALL abandon the byte; the slave SHALL resume only at the next SS falling edge.

Configuration
REQ-029 With macro SPI_SLV_OVR_EN defined, ovr SHALL be sticky per REQ-018 and cleared by any cmd; without it, ovr SHALL be tied 0 and overflowing bytes silently dropped.

Structure
REQ-030 A shared package SHALL hold the config bit positions (CPHA, CPOL, ENDIAN), the dout empty-marker bit index and the TX underrun fill value 8'hFF.
REQ-031 Both FIFOs SHALL be instances of the existing srl_fifo (TX WIDTH 8, RX WIDTH 8); no other sub-module.

Verification
REQ-032 Mode 0, MSB first: wr 8'hA5, master sends 8'h3C -> master receives 8'hA5; rd returns 9'h03C; next rd returns 9'h100.
REQ-033 Mode 3, LSB first: wr 8'h81, master sends 8'h01 -> master receives 8'h81, RX byte 8'h01.
REQ-034 TX FIFO empty, master clocks one byte -> MISO carries 8'hFF; RX byte stored normally.
REQ-035 RX FIFO full, one more byte -> byte dropped, ovr=1 (with SPI_SLV_OVR_EN); cmd -> ovr=0.
REQ-036 SS deasserted after 5 bits, then full byte 8'h55 -> only 8'h55 in RX FIFO; counter restarted.
REQ-037 cmd 3'b011 while SS asserted -> ack=1, mode unchanged; same cmd with SS high -> mode 3 applied.

Source files
------------

// File: rtl/spi_slave_if_pkg.sv
// -----------------------------------------------------------------------------
// spi_slave_if_pkg
// Shared definitions for the SPI slave bus interface: configuration register
// bit positions, the empty-marker bit of the read data word, the byte shifted
// out when the master clocks with nothing queued, FIFO depth, the link state
// encoding and small bit-order helpers used by the shift datapath.
// -----------------------------------------------------------------------------
package spi_slave_if_pkg;

    // Configuration register layout (written from din[2:0] on cmd)
    localparam int CFG_CPHA   = 0;
    localparam int CFG_CPOL   = 1;
    localparam int CFG_ENDIAN = 2;   // 0: MSB first, 1: LSB first

    // dout[8] flags "no byte available" on a read
    localparam int DOUT_EMPTY_BIT = 8;

    // Shifted out to the master when the TX FIFO has nothing queued
    localparam logic [7:0] TX_UNDERRUN_FILL = 8'hFF;

    // Depth of both byte FIFOs (power of two)
    localparam int FIFO_DEPTH = 4;

    // FLUSH holds the link quiet after reset until SS has been seen high
    // through a refilled synchronizer, so a transfer in flight at reset is
    // never picked up half way.
    typedef enum logic [1:0] {
        ST_FLUSH,
        ST_IDLE,
        ST_XFER
    } link_state_t;

    // First bit on the wire for the selected bit order
    function automatic logic head_bit(input logic [7:0] b, input logic lsb_first);
        return lsb_first ? b[0] : b[7];
    endfunction

    // Drop the bit just presented; refill with ones so an idle line stays high
    function automatic logic [7:0] shift_out(input logic [7:0] b, input logic lsb_first);
        return lsb_first ? {1'b1, b[7:1]} : {b[6:0], 1'b1};
    endfunction

    // Accumulate a received bit so the first bit lands at the correct end
    function automatic logic [7:0] shift_in(input logic [7:0] b, input logic in_bit,
                                            input logic lsb_first);
        return lsb_first ? {in_bit, b[7:1]} : {b[6:0], in_bit};
    endfunction

endpackage

// File: rtl/srl_fifo.sv
// -----------------------------------------------------------------------------
// srl_fifo
// Shift-register FIFO: a push shifts every entry one slot deeper, the head is
// read from the slot selected by the fill count. The storage has no reset so
// it maps onto shift-register primitives; only the count is reset.
//
// Parameters: WIDTH data width, DEPTH entries (power of two, >= 2)
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, din     write strobe and data (ignored when full)
//   pop           read strobe (ignored when empty)
//   dout          current head, valid while !empty
//   full, empty   status
// -----------------------------------------------------------------------------
module srl_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count;
    logic [AW-1:0]    rd_idx;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

    // Oldest entry sits at count-1; the truncation wraps count==DEPTH to the
    // last slot, which is why DEPTH must be a power of two.
    assign rd_idx = count[AW-1:0] - 1'b1;
    assign dout   = empty ? '0 : mem[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A simultaneous push and pop shifts in the new entry while the head
    // index stays put, which now addresses the next-oldest entry.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

endmodule

// File: rtl/spi_slave_if.sv
// -----------------------------------------------------------------------------
// spi_slave_if
// SPI slave with an 8-bit bus interface. SCK, SS and MOSI are oversampled by
// clk through SYNC_STAGES flops; edges are found by comparing the last
// synchronizer stage with one extra flop. Mode (CPOL/CPHA) and bit order come
// from a config register that may only change while SS is deasserted.
// Transmit bytes queue in a TX FIFO, received bytes in an RX FIFO.
//
// Optional feature: define SPI_SLV_OVR_EN to make ovr a sticky overrun flag
// (set when a byte completes with the RX FIFO full, cleared by any cmd).
// Without it ovr is tied low and such bytes are dropped silently.
//
// Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   din[7:0]              TX byte on wr; config on cmd (b0 CPHA, b1 CPOL,
//                         b2 0=MSB first / 1=LSB first)
//   cmd, wr, rd           config write, TX byte write, RX byte read strobes
//   dout[8:0]             {0,byte} during a successful rd, else {1,8'h00}
//   ack                   registered acknowledge, one cycle after a strobe
//   ovr                   RX overrun flag
//   spi_sck, spi_ss,
//   spi_mosi              from the external master (SS active low)
//   spi_miso, spi_miso_oe data to the master and its enable
// SCK must run at no more than clk/8.
// -----------------------------------------------------------------------------
module spi_slave_if
    import spi_slave_if_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       cmd,
    input  logic       wr,
    input  logic       rd,
    output logic [8:0] dout,
    output logic       ack,
    output logic       ovr,
    input  logic       spi_sck,
    input  logic       spi_ss,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe
);

    logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
    logic        sck_d, ss_d;
    logic        sck_s, ss_s, mosi_s;

    logic [2:0]  cfg;
    logic        cpha, cpol, endian;

    link_state_t state, state_next;
    logic [1:0]  flush_cnt;
    logic        flush_done;
    logic        ss_fall, ss_rise, in_xfer;

    logic        sck_rise, sck_fall, lead_edge, trail_edge;
    logic        sample, shift, byte_done, load;
    logic [2:0]  bit_cnt;
    logic [7:0]  tx_shift, rx_shift, rx_next, load_byte;
    logic        miso_q;

    logic        tx_push, tx_pop, tx_full, tx_empty;
    logic        rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]  tx_head, rx_head;

    // Synchronizers plus one edge-detect flop for SCK and SS, reset to the
    // idle bus levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync  <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            ss_d      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sck_d     <= sck_s;
            ss_d      <= ss_s;
        end
    end

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign cpha   = cfg[CFG_CPHA];
    assign cpol   = cfg[CFG_CPOL];
    assign endian = cfg[CFG_ENDIAN];

    assign sck_rise   = sck_s & ~sck_d;
    assign sck_fall   = ~sck_s & sck_d;
    assign lead_edge  = cpol ? sck_fall : sck_rise;
    assign trail_edge = cpol ? sck_rise : sck_fall;

    // The synchronizer comes out of reset reading SS high, so a transfer
    // already running would look like a fresh SS fall. The flush counter
    // waits until the chain holds real pin samples before leaving FLUSH.
    assign flush_done = (flush_cnt == 2'(SYNC_STAGES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_FLUSH;
            flush_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == ST_FLUSH && !flush_done) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    // Link FSM: SS falling starts a frame, SS rising ends it.
    always_comb begin
        state_next = state;
        ss_fall    = 1'b0;
        ss_rise    = 1'b0;
        in_xfer    = 1'b0;
        case (state)
            ST_FLUSH: begin
                if (flush_done && ss_s) state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (ss_d && !ss_s) begin
                    ss_fall    = 1'b1;
                    state_next = ST_XFER;
                end
            end
            ST_XFER: begin
                if (ss_s) begin
                    ss_rise    = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    in_xfer = 1'b1;
                end
            end
            default: state_next = ST_FLUSH;
        endcase
    end

    // With CPHA=0 the first bit is already on MISO from the load, so the
    // trailing edge after the last sample (counter back at 0) must not shift.
    always_comb begin
        sample    = in_xfer & (cpha ? trail_edge : lead_edge);
        shift     = in_xfer & (cpha ? lead_edge : trail_edge) & (cpha | (bit_cnt != 3'd0));
        byte_done = sample & (bit_cnt == 3'd7);
        load      = ss_fall | byte_done;
        rx_next   = shift_in(rx_shift, mosi_s, endian);
        load_byte = tx_empty ? TX_UNDERRUN_FILL : tx_head;
    end

    assign tx_pop  = load & ~tx_empty;
    assign tx_push = wr & ~tx_full;
    assign rx_push = byte_done & ~rx_full;
    assign rx_pop  = rd & ~rx_empty;

    // Bit counter, receive accumulator and transmit shifter with MISO register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= 3'd0;
            rx_shift <= 8'h00;
            tx_shift <= TX_UNDERRUN_FILL;
            miso_q   <= 1'b1;
        end else begin
            if (ss_fall || ss_rise) begin
                bit_cnt <= 3'd0;
            end else if (sample) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (sample) begin
                rx_shift <= rx_next;
            end

            if (load) begin
                if (!cpha) begin
                    miso_q   <= head_bit(load_byte, endian);
                    tx_shift <= shift_out(load_byte, endian);
                end else begin
                    tx_shift <= load_byte;
                end
            end else if (shift) begin
                miso_q   <= head_bit(tx_shift, endian);
                tx_shift <= shift_out(tx_shift, endian);
            end
        end
    end

    // Config changes are refused mid-frame but the strobe is still acked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg <= 3'b000;
            ack <= 1'b0;
        end else begin
            ack <= tx_push | rd | cmd;
            if (cmd && ss_s) begin
                cfg <= din[2:0];
            end
        end
    end

`ifdef SPI_SLV_OVR_EN
    logic rx_drop;
    logic ovr_q;

    assign rx_drop = byte_done & rx_full;

    // Overrun wins over a cmd clear in the same cycle so no drop is missed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_q <= 1'b0;
        end else if (rx_drop) begin
            ovr_q <= 1'b1;
        end else if (cmd) begin
            ovr_q <= 1'b0;
        end
    end

    assign ovr = ovr_q;
`else
    assign ovr = 1'b0;
`endif

    always_comb begin
        dout = '0;
        if (rx_pop) begin
            dout[7:0] = rx_head;
        end else begin
            dout[DOUT_EMPTY_BIT] = 1'b1;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = ~ss_s;

    srl_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .din   (din),
        .pop   (tx_pop),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    srl_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (rx_next),
        .pop   (rx_pop),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

endmodule
